// File: rtl/hex_scroll_sequencer.sv
// Scrolls a host-written glyph buffer across HEX5..HEX0 (blank-padded stream, left/right, one-shot or looping).
// Latency: step/done register with the position change; hex outputs follow one cycle later. Optional PASS_COUNT_EN.
// Backpressure: none; pause freezes position and tick, stop aborts to IDLE, buffer writes land in IDLE only.
module hex_scroll_sequencer #(
    parameter int         TICKS_SLOW = 20000000,
    parameter int         TICKS_FAST = 9000000,
    parameter int         MSG_DEPTH  = 16,
    parameter logic [6:0] BLANK      = 7'b1111111
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [6:0]                   wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         dir,
    input  logic                         fastmode,
    input  logic                         loop,
    output logic [6:0]                   hex0,
    output logic [6:0]                   hex1,
    output logic [6:0]                   hex2,
    output logic [6:0]                   hex3,
    output logic [6:0]                   hex4,
    output logic [6:0]                   hex5,
    output logic                         busy,
    output logic                         step,
    output logic                         done
`ifdef PASS_COUNT_EN
    ,
    output logic [7:0]                   pass_cnt
`endif
);

    localparam int AW   = $clog2(MSG_DEPTH);
    localparam int PW   = $clog2(MSG_DEPTH + 7);
    localparam int TMAX = (TICKS_SLOW > TICKS_FAST) ? TICKS_SLOW : TICKS_FAST;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SLOW_LAST = TW'(TICKS_SLOW - 1);
    localparam logic [TW-1:0] FAST_LAST = TW'(TICKS_FAST - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [6:0]    msg_buf [MSG_DEPTH];
    logic [AW:0]   len, len_nxt, len_clamp;
    logic [PW-1:0] pos, pos_nxt, pos_last, pos_inc, pos_dec;
    logic [TW-1:0] tick, tick_nxt, period_last;
    logic          start_ok, step_now, pass_end, step_r, done_r;
    logic [PW:0]   idx_sum [6];
    logic [PW-1:0] idx     [6];
    logic [6:0]    glyph   [6];
    logic [6:0]    hex_r   [6];

    assign len_clamp   = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
    assign pos_last    = PW'(len) + PW'(5);
    assign pos_inc     = (pos == pos_last) ? '0 : pos + PW'(1);
    assign pos_dec     = (pos == '0) ? pos_last : pos - PW'(1);
    assign period_last = fastmode ? FAST_LAST : SLOW_LAST;

    // Window slot k (hex5-k) shows stream index (pos+k) mod N; indices past len are padding.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            glyph[k]   = BLANK;
            idx_sum[k] = {1'b0, pos} + (PW+1)'(k);
            idx[k]     = (idx_sum[k] > {1'b0, pos_last}) ?
                         PW'(idx_sum[k] - {1'b0, pos_last} - (PW+1)'(1)) : idx_sum[k][PW-1:0];
            if (idx[k] < PW'(len))
                glyph[k] = msg_buf[idx[k][AW-1:0]];
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        pos_nxt   = pos;
        tick_nxt  = tick;
        start_ok  = 1'b0;
        step_now  = 1'b0;
        pass_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && msg_len != '0) begin
                    start_ok  = 1'b1;
                    len_nxt   = len_clamp;
                    pos_nxt   = PW'(len_clamp);
                    tick_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop || done_r) begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                end else if (!pause) begin
                    // >= so a switch to the shorter period steps on the very next cycle
                    if (tick >= period_last) begin
                        tick_nxt = '0;
                        step_now = 1'b1;
                        pos_nxt  = dir ? pos_inc : pos_dec;
                        pass_end = (pos_nxt == PW'(len));
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            len    <= '0;
            pos    <= '0;
            tick   <= '0;
            step_r <= 1'b0;
            done_r <= 1'b0;
            for (int k = 0; k < 6; k++) hex_r[k] <= BLANK;
        end else begin
            len    <= len_nxt;
            pos    <= pos_nxt;
            tick   <= tick_nxt;
            step_r <= step_now;
            done_r <= pass_end && !loop;
            for (int k = 0; k < 6; k++)
                hex_r[k] <= (state == RUN && !stop) ? glyph[k] : BLANK;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en && state == IDLE && !start_ok)
            msg_buf[wr_addr] <= wr_data;
    end

`ifdef PASS_COUNT_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            pass_cnt <= '0;
        else if (start_ok)
            pass_cnt <= '0;
        else if (pass_end && pass_cnt != 8'hff)
            pass_cnt <= pass_cnt + 8'd1;
    end
`endif

    assign hex5 = hex_r[0];
    assign hex4 = hex_r[1];
    assign hex3 = hex_r[2];
    assign hex2 = hex_r[3];
    assign hex1 = hex_r[4];
    assign hex0 = hex_r[5];
    assign busy = (state == RUN);
    assign step = step_r;
    assign done = done_r;

endmodule
